// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU-wide types used on the cache/memory boundary.
//   word_t     : 32-bit machine word
//   ramstate_t : state reported by the main-memory stage
//                FREE   - idle, no request in flight
//                BUSY   - request accepted, latency countdown running
//                ACCESS - data phase (one cycle)
//                ERROR  - illegal request on the bus this cycle
// ---------------------------------------------------------------------------
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

// File: rtl/ram_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg
// Local definitions for the ram_timing_ctrl block.
//   ram_fsm_t        : controller FSM state encoding
//   LAT_MIN/LAT_MAX  : legal range of the access latency parameter; the
//                      latency counter is 4 bits wide, hence the upper bound
// ---------------------------------------------------------------------------
package ram_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACC} ram_fsm_t;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
endpackage

// File: rtl/ram_timing_ctrl_if.sv
// ---------------------------------------------------------------------------
// ram_timing_ctrl_if
// RAM request bus between the coherency controller (master) and the
// main-memory stage (slave).
//   ramREN   : read request  (master -> slave)
//   ramWEN   : write request (master -> slave)
//   ramaddr  : byte address  (master -> slave)
//   ramstore : write data    (master -> slave)
//   ramload  : read data     (slave -> master)
//   ramstate : FREE/BUSY/ACCESS/ERROR (slave -> master)
//
// Handshake: the master holds ramREN or ramWEN (never both) together with a
// stable ramaddr/ramstore until ramstate shows ACCESS; that cycle is the
// transfer. ramload is meaningful only on ACCESS of a read. Any change to the
// request while BUSY restarts the latency; dropping both enables abandons it.
// ERROR is reported in the same cycle as an illegal request.
// ---------------------------------------------------------------------------
interface ram_timing_ctrl_if;
  import cpu_types_pkg::*;

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (
    output ramREN, ramWEN, ramaddr, ramstore,
    input  ramload, ramstate
  );

  modport slave (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );
endinterface

// File: rtl/ram_array.sv
// ---------------------------------------------------------------------------
// ram_array
// DEPTH x 32 word storage with one synchronous write port and one
// asynchronous read port sharing a single word index. Contents are not reset.
//   CLK   : clock, rising edge
//   we    : write enable
//   idx   : word index (read and write)
//   wdata : write data
//   rdata : combinational read data at idx
// ---------------------------------------------------------------------------
module ram_array
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 16384,
  localparam int WIDX = $clog2(DEPTH)
) (
  input  logic            CLK,
  input  logic            we,
  input  logic [WIDX-1:0] idx,
  input  word_t           wdata,
  output word_t           rdata
);

  word_t mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/ram_timing_ctrl.sv
// ---------------------------------------------------------------------------
// ram_timing_ctrl
// Main-memory stage behind the coherency controller: a word-addressed SRAM
// with programmable access latency. A valid request is held BUSY for LAT
// cycles and then gets exactly one ACCESS cycle. Any change to the request
// while BUSY restarts the count.
//
// Parameters:
//   LAT   : BUSY cycles before ACCESS (1..15)
//   DEPTH : number of 32-bit words; word index = ramaddr[WIDX+1:2]
//
// Ports:
//   CLK       : clock, rising edge
//   nRST      : asynchronous active-low reset
//   ramif     : RAM request bus (slave side)
//   fsm_state : current controller state, for observation
//
// Build option:
//   RAM_ALIGN_CHECK_EN : when defined, a request with ramaddr[1:0] != 0 is
//                        reported as ERROR; otherwise the low bits are ignored.
// ---------------------------------------------------------------------------
module ram_timing_ctrl
  import cpu_types_pkg::*;
  import ram_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int DEPTH = 16384
) (
  input  logic              CLK,
  input  logic              nRST,
  ram_timing_ctrl_if.slave  ramif,
  output ram_fsm_t          fsm_state
);

  localparam int WIDX = $clog2(DEPTH);
  // Out-of-range LAT values are clamped so the 4-bit counter never wraps.
  localparam int LAT_C = (LAT < LAT_MIN) ? LAT_MIN : ((LAT > LAT_MAX) ? LAT_MAX : LAT);
  localparam logic [3:0] CNT_LOAD = 4'(LAT_C - 1);

  ram_fsm_t   state, state_n;
  logic [3:0] cnt, cnt_n;
  word_t      req_addr, req_addr_n;
  word_t      req_data, req_data_n;
  logic       req_wen, req_wen_n;

  logic  any_req;
  logic  in_range;
  logic  misaligned;
  logic  err;
  logic  valid;
  logic  differs;
  logic  mem_we;
  word_t rd_word;

  assign any_req  = ramif.ramREN | ramif.ramWEN;
  assign in_range = ({2'b00, ramif.ramaddr[31:2]} < 32'(DEPTH));

`ifdef RAM_ALIGN_CHECK_EN
  assign misaligned = (ramif.ramaddr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign err   = (ramif.ramREN & ramif.ramWEN) | (any_req & (~in_range | misaligned));
  assign valid = any_req & ~err;

  // Store data only distinguishes requests when writing.
  assign differs = (ramif.ramaddr != req_addr) |
                   (ramif.ramWEN  != req_wen)  |
                   (ramif.ramWEN & (ramif.ramstore != req_data));

  ram_array #(.DEPTH(DEPTH)) u_array (
    .CLK   (CLK),
    .we    (mem_we),
    .idx   (req_addr[WIDX+1:2]),
    .wdata (req_data),
    .rdata (rd_word)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      req_addr <= '0;
      req_wen  <= 1'b0;
      req_data <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      req_addr <= req_addr_n;
      req_wen  <= req_wen_n;
      req_data <= req_data_n;
    end
  end

  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    req_addr_n     = req_addr;
    req_wen_n      = req_wen;
    req_data_n     = req_data;
    mem_we         = 1'b0;
    ramif.ramstate = FREE;
    ramif.ramload  = '0;

    unique case (state)
      // ACCESS shares the accept logic with IDLE so a held request
      // immediately starts a fresh access.
      S_IDLE, S_ACC: begin
        if (state == S_ACC) begin
          ramif.ramstate = ACCESS;
          mem_we         = req_wen;
          ramif.ramload  = req_wen ? '0 : rd_word;
        end
        if (valid) begin
          req_addr_n = ramif.ramaddr;
          req_wen_n  = ramif.ramWEN;
          req_data_n = ramif.ramstore;
          cnt_n      = CNT_LOAD;
          state_n    = S_WAIT;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_WAIT: begin
        ramif.ramstate = BUSY;
        if (!any_req) begin
          state_n = S_IDLE;
        end else if (differs) begin
          req_addr_n = ramif.ramaddr;
          req_wen_n  = ramif.ramWEN;
          req_data_n = ramif.ramstore;
          cnt_n      = CNT_LOAD;
        end else if (cnt == 4'd0) begin
          state_n = S_ACC;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // An illegal request overrides everything: report it, abandon any
    // in-flight access and suppress the write.
    if (err) begin
      ramif.ramstate = ERROR;
      ramif.ramload  = '0;
      mem_we         = 1'b0;
      state_n        = S_IDLE;
    end
  end

  assign fsm_state = state;

endmodule
